// File: rtl/weight_pkg.sv
// Shared constants and types for the weight store: geometry, the reset image
// of the two weight words, and the encoding of the reward-update FSM.
package weight_pkg;

  localparam int ADDR_W   = 4;
  localparam int DW       = 8;

  // Word addresses of the two packed weight pairs
  localparam int W12_ADDR = 0;
  localparam int W34_ADDR = 1;

  // Reset image: both weight pairs start at (+1, +1), every other word at zero
  localparam logic [7:0] W12_RST   = 8'h11;
  localparam logic [7:0] W34_RST   = 8'h11;
  localparam logic [7:0] OTHER_RST = 8'h00;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_CALC  = 2'd1,
    U_WRITE = 2'd2,
    U_DONE  = 2'd3
  } upd_state_e;

endpackage

// File: rtl/sat_nibble_add.sv
// Signed 4-bit saturating adder. The sum is formed at 5 bits so overflow is
// visible, then clamped to the 4-bit range; clamp_o flags a clamped result.
module sat_nibble_add (
  input  logic signed [3:0] a_i,
  input  logic signed [3:0] b_i,
  output logic signed [3:0] sum_o,
  output logic              clamp_o
);

  function automatic logic [4:0] sat_add4(input logic signed [3:0] a,
                                          input logic signed [3:0] b);
    logic signed [4:0] s;
    s = {a[3], a} + {b[3], b};
    if (s > 5'sd7)       return {1'b1, 4'sd7};
    else if (s < -5'sd8) return {1'b1, -4'sd8};
    else                 return {1'b0, s[3:0]};
  endfunction

  logic [4:0] res;

  // Clamp flag in the top bit, saturated nibble below it
  always_comb begin
    res     = sat_add4(a_i, b_i);
    clamp_o = res[4];
    sum_o   = res[3:0];
  end

endmodule

// File: rtl/weight_store.sv
// Register-file weight store with two independent 1-cycle read ports and a
// 4-state reward-update FSM that saturating-adds signed deltas to the two
// nibbles of a word. Reads in the write cycle see the old word.
module weight_store #(
  parameter int ADDR_W = weight_pkg::ADDR_W,
  parameter int DW     = weight_pkg::DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  output logic              w_valid,
  output logic [DW-1:0]     w_data,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              wb_valid,
  output logic [DW-1:0]     wb_data,
  input  logic              upd_req,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DW-1:0]     upd_delta,
  output logic              upd_ready,
  output logic              upd_done,
  output logic [7:0]        sat_cnt
);

  import weight_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int HW    = DW / 2;

  function automatic logic [7:0] sat_cnt_add(input logic [7:0] cnt,
                                             input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, cnt} + {7'd0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [DW-1:0]     mem_q [DEPTH];
  logic              w_valid_q, wb_valid_q;
  logic [DW-1:0]     w_data_q, wb_data_q;
  upd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0]     delta_q;
  logic [DW-1:0]     word_q;
  logic [7:0]        sat_cnt_q;

  logic [DW-1:0]     cur_word;
  logic signed [HW-1:0] hi_sum, lo_sum;
  logic              hi_clamp, lo_clamp;

  assign cur_word = mem_q[addr_q];

  sat_nibble_add u_add_hi (
    .a_i     (cur_word[DW-1:HW]),
    .b_i     (delta_q[DW-1:HW]),
    .sum_o   (hi_sum),
    .clamp_o (hi_clamp)
  );

  sat_nibble_add u_add_lo (
    .a_i     (cur_word[HW-1:0]),
    .b_i     (delta_q[HW-1:0]),
    .sum_o   (lo_sum),
    .clamp_o (lo_clamp)
  );

  // Storage: reset image on rst, single write port driven by U_WRITE
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == W12_ADDR)      mem_q[i] <= DW'(W12_RST);
        else if (i == W34_ADDR) mem_q[i] <= DW'(W34_RST);
        else                    mem_q[i] <= DW'(OTHER_RST);
      end
    end else if (state_q == U_WRITE) begin
      mem_q[addr_q] <= word_q;
    end
  end

  // Two read ports, both registered; data holds when the port is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      w_data_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      w_valid_q  <= w_req;
      wb_valid_q <= wb_req;
      if (w_req)  w_data_q  <= mem_q[w_addr];
      if (wb_req) wb_data_q <= mem_q[wb_addr];
    end
  end

  // Update FSM next state; requests outside U_IDLE are dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      U_IDLE:  if (upd_req) state_d = U_CALC;
      U_CALC:  state_d = U_WRITE;
      U_WRITE: state_d = U_DONE;
      default: state_d = U_IDLE;
    endcase
  end

  // FSM state and saturation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= U_IDLE;
      sat_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == U_CALC)
        sat_cnt_q <= sat_cnt_add(sat_cnt_q, {1'b0, hi_clamp} + {1'b0, lo_clamp});
    end
  end

  // Update operands latched on accept, result word registered in U_CALC
  always_ff @(posedge clk) begin
    if (state_q == U_IDLE && upd_req) begin
      addr_q  <= upd_addr;
      delta_q <= upd_delta;
    end
    if (state_q == U_CALC)
      word_q <= {hi_sum, lo_sum};
  end

  assign w_valid   = w_valid_q;
  assign w_data    = w_data_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign upd_ready = (state_q == U_IDLE);
  assign upd_done  = (state_q == U_DONE);
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: doc/weight_store.md
WEIGHT_STORE -- requirements
Module: weight_store

Interface
REQ-001 Parameter ADDR_W, default 4, word address width; DEPTH = 2**ADDR_W entries.
REQ-002 Parameter DW, default 8, word width; each word packs two signed 4-bit weights, hi nibble [7:4] and lo nibble [3:0].
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 w_req  input  1  read request, port A (single-cycle pulse).
REQ-006 w_addr  input  ADDR_W  read address, port A.
REQ-007 w_valid  output  1  port A data valid, one-cycle pulse.
REQ-008 w_data  output  DW  port A read data.
REQ-009 wb_req / wb_addr / wb_valid / wb_data  same directions and widths as port A; independent port B.
REQ-010 upd_req  input  1  reward-update request.
REQ-011 upd_addr  input  ADDR_W  word to update.
REQ-012 upd_delta  input  DW  two signed 4-bit deltas, [7:4] for hi nibble, [3:0] for lo nibble.
REQ-013 upd_ready  output  1  high only in U_IDLE.
REQ-014 upd_done  output  1  one-cycle pulse when the update is committed.
REQ-015 sat_cnt  output  8  count of saturated nibble updates.

Function
REQ-016 Storage SHALL be DEPTH x DW registers; address 0 holds W1|W2 and address 1 holds W3|W4.
REQ-017 Read latency SHALL be exactly 1 cycle: w_req high in cycle N gives w_valid=1 in N+1, with w_data = mem[w_addr sampled at N]. Port B behaves the same.
REQ-018 Port A and port B SHALL be serviced in the same cycle, including when both use the same address; there is no arbitration and no stall.
REQ-019 When a read port is idle, w_valid SHALL be 0 and w_data SHALL hold its last value.
REQ-020 The update FSM SHALL have states U_IDLE, U_CALC, U_WRITE and U_DONE.
REQ-021 In U_IDLE, upd_req with upd_ready=1 SHALL latch upd_addr and upd_delta and move to U_CALC; upd_req in any other state SHALL be ignored (not queued).
REQ-022 In U_CALC, each nibble SHALL be computed as sat(mem + delta) using a 5-bit signed intermediate, clamped to +7 / -8, and the result registered; the FSM then moves to U_WRITE.
REQ-023 In U_WRITE, the registered word SHALL be written to mem; the FSM then moves to U_DONE.
REQ-024 In U_DONE, upd_done SHALL be 1 and the FSM SHALL return to U_IDLE. upd_done is asserted 3 cycles after the accept cycle.
REQ-025 A read of the update address issued in the U_WRITE cycle SHALL return the pre-update value; a read issued in any later cycle SHALL return the new value.
REQ-026 A write to the updated word between U_CALC and U_WRITE is not possible (single writer), so no hazard logic is required.
REQ-027 sat_cnt SHALL increment by the number of nibbles clamped in U_CALC (0, 1 or 2) and SHALL saturate at 255.

Reset
REQ-028 On rst, mem[0] and mem[1] SHALL be 8'h11 and all other entries 8'h00.
REQ-029 On rst, w_valid=0, wb_valid=0, w_data=0, wb_data=0, upd_done=0, sat_cnt=0, and the FSM SHALL be in U_IDLE, so upd_ready=1 in the cycle after rst deasserts.
REQ-030 rst asserted mid-update SHALL abort the update with no write, and any pending valid pulse SHALL be dropped.

Structure
REQ-031 Package weight_pkg SHALL hold ADDR_W, DW, W12_ADDR=0, W34_ADDR=1, the reset image constants, and the update FSM state enum.
REQ-032 Sub-module sat_nibble_add SHALL perform the 4-bit signed saturating add and return a clamp flag; it is instantiated twice, once for hi and once for lo.

Verification
REQ-033 After rst: w_req with addr 0 -> next cycle w_valid=1, w_data=8'h11.
REQ-034 Update addr 1, delta 8'h2F (+2, -1) -> upd_done 3 cycles after accept; a following read of addr 1 returns 8'h30; sat_cnt=0.
REQ-035 mem[0]=8'h71, delta 8'h79 (+7, -7) -> mem[0]=8'h7A (hi clamps to +7; lo 1-7=-6 = 4'hA, no clamp); sat_cnt=1.
REQ-036 Port A and port B both read addr 1 in the U_WRITE cycle of an update to addr 1 -> both return the old value; a read one cycle later returns the new value.
REQ-037 rst pulsed during U_CALC -> no upd_done, mem[addr] unchanged, upd_ready=1 the next cycle.
REQ-038 upd_req held high continuously -> exactly one update per 4 cycles, and upd_req during busy states is ignored.
